// File: rtl/layer8_loop_sequencer.sv
// layer8_loop_sequencer: loop-nest controller for the layer-8 conv datapath.
// Steps L (tap, innermost), z (channel group), j (column) and k (row, outermost)
// and emits per-counter wrap flags. A run is started with start/busy/done.
// Optional build macro L8_SEQ_PERF_EN adds perf_cycles_o / perf_stalls_o counters.
module layer8_loop_sequencer #(
    parameter int L_MAX      = 9,
    parameter int J_MAX      = 14,
    parameter int K_MAX      = 14,
    parameter int PIPE_DEPTH = 3,
    parameter int L_W        = 4,
    parameter int J_W        = 4,
    parameter int K_W        = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [2:0]     u_i,
    input  logic           en_i,
    input  logic           abort_i,
    output logic           busy_o,
    output logic           done_o,
    output logic           cfg_err_o,
    output logic           step_valid_o,
    output logic [L_W-1:0] l_cnt_o,
    output logic [1:0]     z_o,
    output logic [J_W-1:0] j_cnt_o,
    output logic [K_W-1:0] k_cnt_o,
    output logic           L_zero_o,
    output logic           z_zero_o,
    output logic           j_zero_o,
    output logic           k_zero_o,
    output logic           last_o
`ifdef L8_SEQ_PERF_EN
    ,
    output logic [31:0]    perf_cycles_o,
    output logic [31:0]    perf_stalls_o
`endif
);

    localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t         state_q, state_d;
    logic [1:0]     mode_q, mode_d;
    logic [L_W-1:0] l_q, l_d;
    logic [1:0]     z_q, z_d;
    logic [J_W-1:0] j_q, j_d;
    logic [K_W-1:0] k_q, k_d;
    logic [DW-1:0]  drain_q, drain_d;
    logic           done_q, done_d;
    logic           cfg_err_q, cfg_err_d;

    logic step, lz, zz, jz, kz, zLast;
    logic accept, reject, drainEnd;

    // A start in IDLE is either accepted (legal mode) or rejected; abort beats both.
    assign accept   = (state_q == S_IDLE) & start_i & ~abort_i & (u_i <= 3'd3);
    assign reject   = (state_q == S_IDLE) & start_i & ~abort_i & (u_i > 3'd3);
    assign drainEnd = (state_q == S_DRAIN) & (drain_q == DW'(PIPE_DEPTH - 1));

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: abort returns to IDLE from anywhere.
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept)   state_d = S_RUN;
                S_RUN:   if (kz)       state_d = S_DRAIN;
                S_DRAIN: if (drainEnd) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output logic: step strobe and the cascaded wrap flags, gated by a firing step.
    always_comb begin
        step = (state_q == S_RUN) & en_i;
        case (mode_q)
            2'd0:    zLast = (z_q == 2'd1);
            2'd1:    zLast = 1'b1;
            default: zLast = (z_q == 2'd3);
        endcase
        lz = step & ((mode_q == 2'd2) | (l_q == L_W'(L_MAX - 1)));
        zz = lz & zLast;
        jz = zz & (j_q == J_W'(J_MAX - 1));
        kz = jz & (k_q == K_W'(K_MAX - 1));
    end

    // Counter next values: cleared outside RUN, nested increment on each step.
    always_comb begin
        l_d = l_q;
        z_d = z_q;
        j_d = j_q;
        k_d = k_q;
        if (abort_i || state_q != S_RUN) begin
            l_d = '0;
            z_d = '0;
            j_d = '0;
            k_d = '0;
        end else if (step) begin
            l_d = lz ? '0 : l_q + L_W'(1);
            if (lz) z_d = zz ? '0 : z_q + 2'd1;
            if (zz) j_d = jz ? '0 : j_q + J_W'(1);
            if (jz) k_d = kz ? '0 : k_q + K_W'(1);
        end
    end

    // Mode latch, drain timer and registered done/cfg_err pulses.
    always_comb begin
        mode_d    = accept ? u_i[1:0] : mode_q;
        drain_d   = (state_q == S_DRAIN && !abort_i && !drainEnd) ? drain_q + DW'(1) : '0;
        done_d    = drainEnd & ~abort_i;
        cfg_err_d = reject;
    end

    // Datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q    <= 2'd0;
            l_q       <= '0;
            z_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            drain_q   <= '0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            l_q       <= l_d;
            z_q       <= z_d;
            j_q       <= j_d;
            k_q       <= k_d;
            drain_q   <= drain_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = done_q;
    assign cfg_err_o    = cfg_err_q;
    assign step_valid_o = step;
    assign l_cnt_o      = l_q;
    assign z_o          = z_q;
    assign j_cnt_o      = j_q;
    assign k_cnt_o      = k_q;
    assign L_zero_o     = lz;
    assign z_zero_o     = zz;
    assign j_zero_o     = jz;
    assign k_zero_o     = kz;
    assign last_o       = kz;

`ifdef L8_SEQ_PERF_EN
    logic [31:0] perfCycles_q, perfStalls_q;

    // Saturating run statistics, cleared when a run is accepted and held afterwards.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perfCycles_q <= '0;
            perfStalls_q <= '0;
        end else if (accept) begin
            perfCycles_q <= '0;
            perfStalls_q <= '0;
        end else begin
            if (state_q != S_IDLE && perfCycles_q != '1)
                perfCycles_q <= perfCycles_q + 32'd1;
            if (state_q == S_RUN && !en_i && perfStalls_q != '1)
                perfStalls_q <= perfStalls_q + 32'd1;
        end
    end

    assign perf_cycles_o = perfCycles_q;
    assign perf_stalls_o = perfStalls_q;
`endif

endmodule

// File: tb/tb_layer8_loop_sequencer.sv
// tb_layer8_loop_sequencer: directed bench for the layer-8 loop sequencer.
// Each step's counters and flags are compared against a div/mod model of the loop nest.
module tb_layer8_loop_sequencer;

    localparam int PIPE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  u;
    logic        en;
    logic        abort;
    logic        busy, done, cfgErr, stepValid;
    logic [3:0]  lCnt;
    logic [1:0]  z;
    logic [3:0]  jCnt, kCnt;
    logic        lZero, zZero, jZero, kZero, last;
`ifdef L8_SEQ_PERF_EN
    logic [31:0] perfCycles, perfStalls;
`endif

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] dutVec;
    assign dutVec = {9'd0, busy, stepValid, done, cfgErr, lCnt, z, jCnt, kCnt,
                     lZero, zZero, jZero, kZero, last};

    layer8_loop_sequencer dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .u_i          (u),
        .en_i         (en),
        .abort_i      (abort),
        .busy_o       (busy),
        .done_o       (done),
        .cfg_err_o    (cfgErr),
        .step_valid_o (stepValid),
        .l_cnt_o      (lCnt),
        .z_o          (z),
        .j_cnt_o      (jCnt),
        .k_cnt_o      (kCnt),
        .L_zero_o     (lZero),
        .z_zero_o     (zZero),
        .j_zero_o     (jZero),
        .k_zero_o     (kZero),
        .last_o       (last)
`ifdef L8_SEQ_PERF_EN
        ,
        .perf_cycles_o(perfCycles),
        .perf_stalls_o(perfStalls)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expVec(input logic b, input logic sv, input logic d,
                                           input logic ce, input int l, input int zz,
                                           input int j, input int k, input logic f0,
                                           input logic f1, input logic f2, input logic f3);
        logic [3:0] l4, j4, k4;
        logic [1:0] z2;
        l4 = 4'(l);
        z2 = 2'(zz);
        j4 = 4'(j);
        k4 = 4'(k);
        return {9'd0, b, sv, d, ce, l4, z2, j4, k4, f0, f1, f2, f3, f3};
    endfunction

    // Runs one job: stopAt>0 returns mid-run after that many steps, pokeStep injects
    // a bad start while busy, toggleEn alternates en starting with 1.
    task automatic applyStimulus(input int mode, input bit toggleEn, input int pokeStep,
                                 input int stopAt, input string tag);
        int lext, zext, total, s, cyc, runCycles;
        int l, zz, j, k;
        logic f0, f1, f2, f3;
        lext  = (mode == 2) ? 1 : 9;
        zext  = (mode == 0) ? 2 : ((mode == 1) ? 1 : 4);
        total = lext * zext * 14 * 14;
        s   = 0;
        cyc = 0;
        @(negedge clk);
        start = 1'b1;
        u     = 3'(mode);
        abort = 1'b0;
        en    = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            u     = 3'd0;
            en    = toggleEn ? (cyc % 2 == 1) : 1'b1;
            if (pokeStep >= 0 && s == pokeStep && en) begin
                start = 1'b1;
                u     = 3'd5;
            end
            #1;
            l  = s % lext;
            zz = (s / lext) % zext;
            j  = (s / (lext * zext)) % 14;
            k  = s / (lext * zext * 14);
            f0 = en && (l == lext - 1);
            f1 = f0 && (zz == zext - 1);
            f2 = f1 && (j == 13);
            f3 = f2 && (k == 13);
            checkOutput(tag, dutVec, expVec(1'b1, en, 1'b0, 1'b0, l, zz, j, k, f0, f1, f2, f3));
            if (en) s++;
            if (s == total) break;
            if (stopAt > 0 && s == stopAt) return;
            if (cyc > 4 * total + 100) begin
                checkOutput({tag, "_timeout"}, 32'd1, 32'd0);
                return;
            end
        end
        runCycles = toggleEn ? 2 * total - 1 : total;
        checkOutput({tag, "_runcycles"}, 32'(cyc), 32'(runCycles));
        for (int d = 0; d < PIPE; d++) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            en    = 1'b1;
            #1;
            checkOutput({tag, "_drain"}, dutVec, expVec(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        @(negedge clk);
        cyc++;
        #1;
        checkOutput({tag, "_done"}, dutVec, expVec(1'b0, 0, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        checkOutput({tag, "_donecycle"}, 32'(cyc), 32'(runCycles + PIPE + 1));
`ifdef L8_SEQ_PERF_EN
        checkOutput({tag, "_perfstalls"}, perfStalls, toggleEn ? 32'(total - 1) : 32'd0);
        checkOutput({tag, "_perfcycles"}, perfCycles, 32'(runCycles + PIPE));
`endif
        @(negedge clk);
        #1;
        checkOutput({tag, "_donepulse"}, dutVec, 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        u     = 3'd0;
        en    = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset", dutVec, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(3, 1'b0, -1, 0, "u3");
        applyStimulus(2, 1'b0, -1, 0, "u2");
        applyStimulus(1, 1'b0, 50, 0, "u1_poke");

        // Illegal mode: cfg_err pulse, no run.
        @(negedge clk);
        start = 1'b1;
        u     = 3'd5;
        @(negedge clk);
        start = 1'b0;
        u     = 3'd0;
        #1;
        checkOutput("cfg_err_pulse", dutVec, expVec(0, 0, 0, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        #1;
        checkOutput("cfg_err_clear", dutVec, 32'd0);

        // Abort together with start: abort wins.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        en    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1;
        checkOutput("abort_start", dutVec, 32'd0);

        // Abort after 100 steps, then immediate restart with en toggling.
        applyStimulus(0, 1'b0, -1, 100, "u0_pre_abort");
        @(negedge clk);
        abort = 1'b1;
        en    = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        en    = 1'b0;
        #1;
        checkOutput("abort_idle", dutVec, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput("abort_nodone", dutVec, 32'd0);
        end
        applyStimulus(0, 1'b1, -1, 0, "u0_toggle");

        // Asynchronous reset mid-run, then a normal run.
        applyStimulus(3, 1'b0, -1, 20, "u3_pre_rst");
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset", dutVec, 32'd0);
        @(negedge clk);
        #1;
        checkOutput("reset_hold", dutVec, 32'd0);
        rst = 1'b0;
        applyStimulus(2, 1'b0, -1, 0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
